isa_cycle_engine: RTL and testbench

// Parametrised ISA bus cycle engine for the riser; successor to the fixed IOR/IOW state machine.

---
 rtl/isa_cycle_engine_if.sv | 35 +++
 rtl/isa_cycle_engine.sv | 260 ++++++++++++++++++++++++++
 tb/tb_isa_cycle_engine.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_cycle_engine_if.sv
// ----------------------------------------------------------------------------
// isa_cycle_engine_if
// Host-side command/response handshake of the ISA cycle engine.
//   cmd_valid/cmd_ready : one command per handshake
//   cmd_write/mem/wide  : cycle type (write, memory space, 16-bit)
//   cmd_addr/cmd_wdata  : cycle address and write data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata           : read data, held until the next completion
//   rsp_timeout         : completion was an IOCHRDY timeout abort
// Modports: master = host (register file), slave = engine.
// ----------------------------------------------------------------------------
interface isa_cycle_engine_if #(
    parameter int ADDR_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic              cmd_mem;
    logic              cmd_wide;
    logic [ADDR_W-1:0] cmd_addr;
    logic [15:0]       cmd_wdata;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic              rsp_timeout;

    modport master (
        output cmd_valid, cmd_write, cmd_mem, cmd_wide, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_mem, cmd_wide, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_timeout
    );
endinterface

// File: rtl/isa_cycle_engine.sv
// ----------------------------------------------------------------------------
// isa_cycle_engine
// Runs one host command as an ISA I/O or memory cycle (8- or 16-bit) with
// programmable setup/strobe/hold timing, IOCHRDY wait states with timeout,
// a RESET pulse on the bus after reset release and IRQ rising-edge latching.
// Ports:
//   clk, reset        : bus clock, asynchronous active-low reset
//   host              : command/response handshake (slave modport)
//   bus_a, bus_d_out, bus_d_oe, bus_d_in : ISA address and data pins
//   bus_ale, bus_ior_n, bus_iow_n, bus_memr_n, bus_memw_n, bus_sbhe_n
//                     : ISA control outputs (strobes and SBHE active low)
//   bus_iochrdy       : device ready, low inserts wait states (asynchronous)
//   bus_reset         : ISA RESET, active high
//   irq_in, irq_clear, irq_pending : raw IRQ lines, per-line clear, latched edges
// ----------------------------------------------------------------------------
module isa_cycle_engine #(
    parameter int ADDR_W        = 16,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int READY_TIMEOUT = 256,
    parameter int NUM_IRQ       = 4,
    parameter int RESET_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               reset,
    isa_cycle_engine_if.slave  host,
    output logic [ADDR_W-1:0]  bus_a,
    output logic [15:0]        bus_d_out,
    output logic               bus_d_oe,
    input  logic [15:0]        bus_d_in,
    output logic               bus_ale,
    output logic               bus_ior_n,
    output logic               bus_iow_n,
    output logic               bus_memr_n,
    output logic               bus_memw_n,
    output logic               bus_sbhe_n,
    input  logic               bus_iochrdy,
    output logic               bus_reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_clear,
    output logic [NUM_IRQ-1:0] irq_pending
);

    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_STROBE = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // One phase counter is shared by the reset pulse and every cycle phase.
    localparam int MAX_AB  = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_CD  = (HOLD_CYCLES > RESET_CYCLES) ? HOLD_CYCLES : RESET_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = $clog2(READY_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(READY_TIMEOUT);

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               write_q, write_d;
    logic               mem_q, mem_d;
    logic               wide_q, wide_d;       // effective width: odd address forces 8-bit
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;     // already byte-replicated for narrow writes
    logic [15:0]        cap_q, cap_d;         // data captured at strobe exit
    logic               timeout_q, timeout_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               rdy_s1_q, rdy_s1_d;
    logic               rdy_s2_q, rdy_s2_d;
    logic [NUM_IRQ-1:0] irq_s1_q, irq_s1_d;
    logic [NUM_IRQ-1:0] irq_s2_q, irq_s2_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ-1:0] irq_pend_q, irq_pend_d;

    logic               wide_eff;
    logic               in_cycle;
    logic               strobe_on;

    assign wide_eff = host.cmd_wide & ~host.cmd_addr[0];

    // ------------------------------------------------------------------
    // Cycle sequencer
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        write_d   = write_q;
        mem_d     = mem_q;
        wide_d    = wide_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cap_d     = cap_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;

        case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_IDLE: begin
                if (host.cmd_valid) begin
                    write_d   = host.cmd_write;
                    mem_d     = host.cmd_mem;
                    wide_d    = wide_eff;
                    addr_d    = host.cmd_addr;
                    wdata_d   = wide_eff ? host.cmd_wdata : {2{host.cmd_wdata[7:0]}};
                    timeout_d = 1'b0;
                    wait_d    = '0;
                    cnt_d     = '0;
                    state_d   = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_STROBE: begin
                // The counter parks on the last minimum cycle; from there on
                // every not-ready cycle is a wait state.
                if (cnt_q != STROBE_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (rdy_s2_q) begin
                    cap_d   = wide_q ? bus_d_in : {8'h00, bus_d_in[7:0]};
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (wait_q == WAIT_LIMIT) begin
                    cap_d     = 16'hFFFF;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_HOLD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    // Read data becomes visible together with rsp_valid.
                    if (!write_q) begin
                        rdata_d = cap_q;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Synchronisers and IRQ edge latching (active in every state)
    // ------------------------------------------------------------------
    always_comb begin
        rdy_s1_d   = bus_iochrdy;
        rdy_s2_d   = rdy_s1_q;
        irq_s1_d   = irq_in;
        irq_s2_d   = irq_s1_q;
        irq_prev_d = irq_s2_q;
        // A new edge wins over a clear arriving in the same cycle.
        irq_pend_d = (irq_pend_q & ~irq_clear) | (irq_s2_q & ~irq_prev_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RST;
            cnt_q      <= '0;
            wait_q     <= '0;
            write_q    <= 1'b0;
            mem_q      <= 1'b0;
            wide_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            timeout_q  <= 1'b0;
            rdata_q    <= '0;
            rdy_s1_q   <= 1'b1;
            rdy_s2_q   <= 1'b1;
            irq_s1_q   <= '0;
            irq_s2_q   <= '0;
            irq_prev_q <= '0;
            irq_pend_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            write_q    <= write_d;
            mem_q      <= mem_d;
            wide_q     <= wide_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cap_q      <= cap_d;
            timeout_q  <= timeout_d;
            rdata_q    <= rdata_d;
            rdy_s1_q   <= rdy_s1_d;
            rdy_s2_q   <= rdy_s2_d;
            irq_s1_q   <= irq_s1_d;
            irq_s2_q   <= irq_s2_d;
            irq_prev_q <= irq_prev_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state flops, so an asynchronous reset drops
    // the strobes immediately, even in the middle of a cycle.
    // ------------------------------------------------------------------
    assign in_cycle  = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);
    assign strobe_on = (state_q == ST_STROBE);

    assign host.cmd_ready   = (state_q == ST_IDLE);
    assign host.rsp_valid   = (state_q == ST_DONE);
    assign host.rsp_timeout = (state_q == ST_DONE) & timeout_q;
    assign host.rsp_rdata   = rdata_q;

    assign bus_reset  = (state_q == ST_RST);
    assign bus_a      = addr_q;
    assign bus_d_out  = wdata_q;
    assign bus_d_oe   = in_cycle & write_q;
    assign bus_ale    = (state_q == ST_SETUP) && (cnt_q == '0);
    assign bus_sbhe_n = ~(in_cycle & wide_q);
    assign bus_ior_n  = ~(strobe_on & ~mem_q & ~write_q);
    assign bus_iow_n  = ~(strobe_on & ~mem_q &  write_q);
    assign bus_memr_n = ~(strobe_on &  mem_q & ~write_q);
    assign bus_memw_n = ~(strobe_on &  mem_q &  write_q);

    assign irq_pending = irq_pend_q;

endmodule

// File: tb/tb_isa_cycle_engine.sv
// ----------------------------------------------------------------------------
// tb_isa_cycle_engine
// Directed bench for isa_cycle_engine with default parameters. Outputs are
// sampled on the falling edge; period k is the clock period that follows the
// k-1'th rising edge after the command-accept edge.
// ----------------------------------------------------------------------------
module tb_isa_cycle_engine;

    logic        clk;
    logic        reset;
    logic [15:0] bus_a;
    logic [15:0] bus_d_out;
    logic        bus_d_oe;
    logic [15:0] bus_d_in;
    logic        bus_ale;
    logic        bus_ior_n;
    logic        bus_iow_n;
    logic        bus_memr_n;
    logic        bus_memw_n;
    logic        bus_sbhe_n;
    logic        bus_iochrdy;
    logic        bus_reset;
    logic [3:0]  irq_in;
    logic [3:0]  irq_clear;
    logic [3:0]  irq_pending;

    isa_cycle_engine_if #(.ADDR_W(16)) host_if ();

    isa_cycle_engine dut (
        .clk         (clk),
        .reset       (reset),
        .host        (host_if),
        .bus_a       (bus_a),
        .bus_d_out   (bus_d_out),
        .bus_d_oe    (bus_d_oe),
        .bus_d_in    (bus_d_in),
        .bus_ale     (bus_ale),
        .bus_ior_n   (bus_ior_n),
        .bus_iow_n   (bus_iow_n),
        .bus_memr_n  (bus_memr_n),
        .bus_memw_n  (bus_memw_n),
        .bus_sbhe_n  (bus_sbhe_n),
        .bus_iochrdy (bus_iochrdy),
        .bus_reset   (bus_reset),
        .irq_in      (irq_in),
        .irq_clear   (irq_clear),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observations of the last command
    int          o_str_len, o_oe_len, o_ale_len, o_rsp_at;
    logic [3:0]  o_mask;          // {memw, memr, iow, ior} seen low
    logic        o_tmo, o_sbhe_low, o_busy_ready, o_after_valid, o_after_ready;
    logic [15:0] o_rdata, o_dout, o_addr;

    function automatic logic [3:0] strobe_mask();
        return {~bus_memw_n, ~bus_memr_n, ~bus_iow_n, ~bus_ior_n};
    endfunction

    task automatic issue(input logic wr, input logic mem, input logic wide,
                         input logic [15:0] addr, input logic [15:0] wdata);
        int t = 0;
        @(negedge clk);
        while (!host_if.cmd_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready", 32'(host_if.cmd_ready), 32'd1);
        host_if.cmd_write = wr;
        host_if.cmd_mem   = mem;
        host_if.cmd_wide  = wide;
        host_if.cmd_addr  = addr;
        host_if.cmd_wdata = wdata;
        host_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        host_if.cmd_valid = 1'b0;
    endtask

    // Issue a command and watch it to completion. When rdy_len > 0 the bench
    // drives IOCHRDY low at the falling edge of periods rdy_start..rdy_start+rdy_len-1.
    task automatic run_cmd(input logic wr, input logic mem, input logic wide,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input int rdy_start, input int rdy_len);
        issue(wr, mem, wide, addr, wdata);
        o_str_len = 0; o_oe_len = 0; o_ale_len = 0; o_rsp_at = -1;
        o_mask = '0; o_tmo = 1'b0; o_sbhe_low = 1'b0; o_busy_ready = 1'b1;
        o_rdata = '0; o_dout = '0; o_addr = '0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) o_busy_ready = host_if.cmd_ready;
            if (|strobe_mask()) begin
                o_str_len++;
                o_mask = o_mask | strobe_mask();
                o_dout = bus_d_out;
                o_addr = bus_a;
            end
            if (bus_d_oe) o_oe_len++;
            if (bus_ale) o_ale_len++;
            if (!bus_sbhe_n) o_sbhe_low = 1'b1;
            if (host_if.rsp_valid) begin
                o_rsp_at = k;
                o_tmo    = host_if.rsp_timeout;
                o_rdata  = host_if.rsp_rdata;
                break;
            end
            if (rdy_len > 0) bus_iochrdy = !(k >= rdy_start && k < rdy_start + rdy_len);
        end
        @(negedge clk);
        o_after_valid = host_if.rsp_valid;
        o_after_ready = host_if.cmd_ready;
    endtask

    initial begin
        int n;
        reset             = 1'b0;
        bus_d_in          = 16'h0000;
        bus_iochrdy       = 1'b1;
        irq_in            = '0;
        irq_clear         = '0;
        host_if.cmd_valid = 1'b0;
        host_if.cmd_write = 1'b0;
        host_if.cmd_mem   = 1'b0;
        host_if.cmd_wide  = 1'b0;
        host_if.cmd_addr  = '0;
        host_if.cmd_wdata = '0;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_strobes", 32'(strobe_mask()), 32'h0);
        check("rst_sbhe_n", 32'(bus_sbhe_n), 32'd1);
        check("rst_bus_reset", 32'(bus_reset), 32'd1);
        check("rst_cmd_ready", 32'(host_if.cmd_ready), 32'd0);
        check("rst_bus_a", 32'(bus_a), 32'h0);
        check("rst_d_oe_ale", 32'({bus_d_oe, bus_ale}), 32'h0);
        check("rst_rsp", 32'({host_if.rsp_valid, host_if.rsp_timeout, host_if.rsp_rdata}), 32'h0);
        check("rst_irq", 32'(irq_pending), 32'h0);

        // ---------------- bus reset pulse length ----------------
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (!bus_reset) break;
        end
        check("bus_reset_len", 32'(n), 32'd16);
        check("ready_after_rst", 32'(host_if.cmd_ready), 32'd1);
        check("strobes_after_rst", 32'(strobe_mask()), 32'h0);

        // ---------------- narrow IO write ----------------
        run_cmd(1'b1, 1'b0, 1'b0, 16'h0220, 16'h00A5, 0, 0);
        check("iow_mask", 32'(o_mask), 32'b0010);
        check("iow_len", 32'(o_str_len), 32'd4);
        check("iow_oe_len", 32'(o_oe_len), 32'd6);
        check("iow_ale_len", 32'(o_ale_len), 32'd1);
        check("iow_rsp_at", 32'(o_rsp_at), 32'd7);
        check("iow_tmo", 32'(o_tmo), 32'd0);
        check("iow_dout", 32'(o_dout), 32'hA5A5);
        check("iow_addr", 32'(o_addr), 32'h0220);
        check("iow_sbhe", 32'(o_sbhe_low), 32'd0);
        check("iow_busy_ready", 32'(o_busy_ready), 32'd0);
        check("iow_rdata_held", 32'(o_rdata), 32'h0000);
        check("iow_pulse_len", 32'({o_after_valid, o_after_ready}), 32'b01);

        // ---------------- wide memory read with wait states ----------------
        bus_d_in = 16'h1234;
        run_cmd(1'b0, 1'b1, 1'b1, 16'h0D00, 16'h0000, 3, 10);
        check("memr_mask", 32'(o_mask), 32'b0100);
        check("memr_len", 32'(o_str_len), 32'd14);
        check("memr_oe_len", 32'(o_oe_len), 32'd0);
        check("memr_rsp_at", 32'(o_rsp_at), 32'd17);
        check("memr_rdata", 32'(o_rdata), 32'h1234);
        check("memr_tmo", 32'(o_tmo), 32'd0);
        check("memr_sbhe", 32'(o_sbhe_low), 32'd1);
        check("memr_addr", 32'(o_addr), 32'h0D00);

        // ---------------- wide IO read at odd address ----------------
        bus_iochrdy = 1'b1;
        bus_d_in    = 16'hBEEF;
        run_cmd(1'b0, 1'b0, 1'b1, 16'h0221, 16'h0000, 0, 0);
        check("odd_mask", 32'(o_mask), 32'b0001);
        check("odd_len", 32'(o_str_len), 32'd4);
        check("odd_sbhe", 32'(o_sbhe_low), 32'd0);
        check("odd_rdata", 32'(o_rdata), 32'h00EF);
        check("odd_rsp_at", 32'(o_rsp_at), 32'd7);

        // ---------------- wide memory write ----------------
        run_cmd(1'b1, 1'b1, 1'b1, 16'h0400, 16'h1357, 0, 0);
        check("memw_mask", 32'(o_mask), 32'b1000);
        check("memw_dout", 32'(o_dout), 32'h1357);
        check("memw_sbhe", 32'(o_sbhe_low), 32'd1);
        check("memw_oe_len", 32'(o_oe_len), 32'd6);
        check("memw_rdata_held", 32'(o_rdata), 32'h00EF);

        // ---------------- IO read, IOCHRDY stuck low ----------------
        bus_iochrdy = 1'b0;
        bus_d_in    = 16'h5555;
        run_cmd(1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000, 0, 0);
        check("tmo_len", 32'(o_str_len), 32'd260);
        check("tmo_flag", 32'(o_tmo), 32'd1);
        check("tmo_rdata", 32'(o_rdata), 32'hFFFF);
        check("tmo_rsp_at", 32'(o_rsp_at), 32'd263);
        bus_iochrdy = 1'b1;

        // ---------------- IRQ edge with same-cycle clear ----------------
        @(negedge clk);
        irq_in[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("irq_before_set", 32'(irq_pending), 32'h0);
        irq_clear[2] = 1'b1;
        @(posedge clk);
        #1;
        irq_clear[2] = 1'b0;
        check("irq_set_wins", 32'(irq_pending), 32'b0100);
        irq_in[2] = 1'b0;
        irq_in[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("irq_line1", 32'(irq_pending), 32'b0110);
        irq_clear[1] = 1'b1;
        @(posedge clk);
        #1;
        irq_clear[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_clear1", 32'(irq_pending), 32'b0100);

        // ---------------- reset in the middle of a strobe ----------------
        bus_iochrdy = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 16'h0300, 16'h0000);
        repeat (3) @(negedge clk);
        check("mid_strobe_active", 32'(strobe_mask()), 32'b0001);
        #2;
        reset  = 1'b0;
        irq_in = 4'b0000;
        #1;
        check("mid_rst_strobes", 32'(strobe_mask()), 32'h0);
        check("mid_rst_ctrl", 32'({bus_reset, host_if.cmd_ready, bus_d_oe, bus_sbhe_n}), 32'b1001);
        check("mid_rst_irq", 32'(irq_pending), 32'h0);
        irq_in[0] = 1'b1;
        @(negedge clk);
        bus_iochrdy = 1'b1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("irq_in_rst_state", 32'({bus_reset, irq_pending}), 32'b1_0001);

        // ---------------- engine usable after reset ----------------
        bus_d_in = 16'hAB42;
        run_cmd(1'b0, 1'b0, 1'b0, 16'h0060, 16'h0000, 0, 0);
        check("post_rst_rdata", 32'(o_rdata), 32'h0042);
        check("post_rst_rsp_at", 32'(o_rsp_at), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
